simd_result_unpacker: RTL and testbench
=======================================

SIMD_RESULT_UNPACKER -- requirements
Module: simd_result_unpacker

Interface
REQ-001 Parameter: CARRY_EXT, default 1, 1 = lane carry placed above lane MSB in out_data; 0 = lane carry dropped and out_data zero-extended.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-low reset.
REQ-005 Port: USE_SIMD  input  2  lane mode, sampled with S: 00 = one 32-bit lane, 01 = two 16-bit lanes, 10 = four 8-bit lanes, 11 = eight 4-bit lanes.
REQ-006 Port: S  input  32  packed ALU sum word, lane 0 in the LSBs.
REQ-007 Port: result_SIMD_carry_out  input  8  per-4-bit-slice carry flags from the ALU, bit i belongs to S[4i+3:4i].
REQ-008 Port: in_valid  input  1  S, flags and USE_SIMD valid.
REQ-009 Port: in_ready  output  1  block can capture a packed word.
REQ-010 Port: out_data  output  33  current lane result, LSB-aligned.
REQ-011 Port: out_lane  output  3  index of current lane.
REQ-012 Port: out_last  output  1  current lane is the last lane of the word.
REQ-013 Port: out_valid  output  1  out_data, out_lane and out_last valid.
REQ-014 Port: out_ready  input  1  consumer accepts the current lane.
REQ-015 Port: beat_count  output  16  count of accepted output beats, wraps 16'hFFFF -> 0.

Function
REQ-016 Input capture: S, result_SIMD_carry_out and USE_SIMD are registered on a cycle with in_valid && in_ready.
REQ-017 FSM: two states, IDLE and EMIT; IDLE -> EMIT on capture; EMIT -> IDLE on accepted last beat with no same-cycle capture; EMIT -> EMIT on accepted last beat with same-cycle capture.
REQ-018 Readiness: in_ready = 1 in IDLE, and in EMIT only in the cycle where out_valid && out_ready && out_last (zero-bubble back-to-back words).
REQ-019 Latency: out_valid rises the cycle after capture, with out_lane = 0.
REQ-020 Lane count: 1, 2, 4 or 8 for USE_SIMD 00, 01, 10, 11; lane width 32, 16, 8 or 4 bits.
REQ-021 Lane data: lane k is S[(k+1)*W-1 : k*W], where W is the lane width.
REQ-022 Lane carry: lane carry is result_SIMD_carry_out[(k+1)*W/4-1], the top slice of the lane.
REQ-023 Output format, CARRY_EXT = 1: out_data = {zeros, carry, lane data}, with the carry at bit W.
REQ-024 Output format, CARRY_EXT = 0: out_data = {zeros, lane data}.
REQ-025 Lane advance: out_lane increments on each accepted beat (out_valid && out_ready).
REQ-026 out_last: out_last = 1 exactly when out_lane = lane count - 1.
REQ-027 Backpressure: while out_valid && !out_ready, out_data, out_lane and out_last hold stable, and out_valid stays 1.
REQ-028 Mode changes: a USE_SIMD change while in EMIT has no effect on the word being emitted; only the captured mode applies.
REQ-029 beat_count: beat_count increments by 1 on every accepted beat.

Reset
REQ-030 Reset values: on reset low, immediately and asynchronously, state = IDLE, out_valid = 0, out_data = 0, out_lane = 0, out_last = 0, beat_count = 0, captured registers = 0.
REQ-031 Reset mid-word: reset asserted in EMIT discards the captured word, and no further lanes of it are emitted after release.
REQ-032 Reset release: in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-033 Scenario, 4-bit lanes: USE_SIMD=11, S=32'h8765_4321, flags=8'b1000_0001, out_ready=1 -> 8 beats over 8 cycles, out_data 0x11,0x2,0x3,0x4,0x5,0x6,0x7,0x18, out_last only on lane 7.
REQ-034 Scenario, 16-bit lanes: USE_SIMD=01, S=32'hFFFF_0001, flags=8'b1000_1000 -> out_data 33'h1_0001 then 33'h1_FFFF; with CARRY_EXT=0 -> 33'h0_0001 then 33'h0_FFFF.
REQ-035 Scenario, 32-bit lane: USE_SIMD=00, S=32'hDEAD_BEEF, flags bit7=1 -> single beat, out_data 33'h1_DEAD_BEEF, out_lane 0, out_last 1, in_ready 1 in that beat's accept cycle.
REQ-036 Scenario, backpressure: USE_SIMD=10, S=32'h4433_2211, flags=0, out_ready held 0 for 3 cycles on lane 1 -> out_data 0x22 held stable for 3 cycles, then lanes 0x33 and 0x44 follow, beat_count = 4.
REQ-037 Scenario, back-to-back: second word presented with in_valid=1 during the first word's last beat -> captured that cycle, lane 0 of the second word is valid in the next cycle, with no idle cycle.
REQ-038 Scenario, reset mid-word: reset pulsed low during lane 2 of an 8-lane word -> outputs clear within the reset pulse, no lane 3 is emitted afterward, beat_count = 0.

Source files
------------

// File: rtl/simd_result_unpacker.sv
// simd_result_unpacker
//   Captures one packed ALU sum word (plus its per-4-bit-slice carry flags and lane mode)
//   and streams it out one lane per accepted beat, LSB lane first.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous active-low reset
//   USE_SIMD[1:0]          lane mode: 00=1x32, 01=2x16, 10=4x8, 11=8x4 (sampled with S)
//   S[31:0]                packed sum word, lane 0 in the LSBs
//   result_SIMD_carry_out  carry flag per 4-bit slice, bit i belongs to S[4i+3:4i]
//   in_valid / in_ready    input handshake
//   out_data[32:0]         current lane, LSB-aligned; lane carry at bit W when CARRY_EXT=1
//   out_lane[2:0]          index of the current lane
//   out_last               current lane is the last lane of the word
//   out_valid / out_ready  output handshake
//   beat_count[15:0]       accepted output beats, wrapping

module simd_result_unpacker #(
    parameter int unsigned CARRY_EXT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  USE_SIMD,
    input  logic [31:0] S,
    input  logic [7:0]  result_SIMD_carry_out,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] out_data,
    output logic [2:0]  out_lane,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] beat_count
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e      state_q, state_d;
    logic [31:0] s_q, s_d;
    logic [7:0]  flags_q, flags_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  lane_q, lane_d;
    logic [15:0] beat_count_q, beat_count_d;

    logic        accept;
    logic        last_accept;
    logic        capture;
    logic        is_last;
    logic [2:0]  last_idx;
    logic [31:0] lane_data;
    logic        lane_carry;
    logic [5:0]  lane_w;

    // Lane decode from the captured word only, so USE_SIMD changes mid-word are ignored.
    always_comb begin
        last_idx   = 3'd0;
        lane_data  = s_q;
        lane_carry = flags_q[7];
        lane_w     = 6'd32;
        unique case (mode_q)
            2'b00: begin
                last_idx   = 3'd0;
                lane_data  = s_q;
                lane_carry = flags_q[7];
                lane_w     = 6'd32;
            end
            2'b01: begin
                last_idx   = 3'd1;
                lane_data  = (s_q >> {lane_q[0], 4'b0000}) & 32'h0000_FFFF;
                lane_carry = flags_q[{lane_q[0], 2'b11}];
                lane_w     = 6'd16;
            end
            2'b10: begin
                last_idx   = 3'd3;
                lane_data  = (s_q >> {lane_q[1:0], 3'b000}) & 32'h0000_00FF;
                lane_carry = flags_q[{lane_q[1:0], 1'b1}];
                lane_w     = 6'd8;
            end
            2'b11: begin
                last_idx   = 3'd7;
                lane_data  = (s_q >> {lane_q, 2'b00}) & 32'h0000_000F;
                lane_carry = flags_q[lane_q];
                lane_w     = 6'd4;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid   = (state_q == StEmit);
        is_last     = (lane_q == last_idx);
        out_last    = out_valid && is_last;
        out_lane    = lane_q;
        accept      = out_valid && out_ready;
        last_accept = accept && is_last;
        // Accepting a new word on the last beat keeps back-to-back words bubble-free.
        in_ready    = (state_q == StIdle) || last_accept;
        capture     = in_valid && in_ready;

        out_data = 33'd0;
        if (out_valid) begin
            out_data = {1'b0, lane_data};
            if (CARRY_EXT != 0) begin
                out_data = out_data | (33'(lane_carry) << lane_w);
            end
        end
        beat_count = beat_count_q;
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        flags_d      = flags_q;
        mode_d       = mode_q;
        lane_d       = lane_q;
        beat_count_d = beat_count_q + {15'd0, accept};

        if (accept) begin
            lane_d = last_accept ? 3'd0 : lane_q + 3'd1;
        end

        if (capture) begin
            s_d     = S;
            flags_d = result_SIMD_carry_out;
            mode_d  = USE_SIMD;
            lane_d  = 3'd0;
        end

        unique case (state_q)
            StIdle: if (capture) state_d = StEmit;
            StEmit: if (last_accept && !capture) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            s_q          <= 32'd0;
            flags_q      <= 8'd0;
            mode_q       <= 2'd0;
            lane_q       <= 3'd0;
            beat_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            flags_q      <= flags_d;
            mode_q       <= mode_d;
            lane_q       <= lane_d;
            beat_count_q <= beat_count_d;
        end
    end

endmodule

// File: tb/tb_simd_result_unpacker.sv
// Directed bench for simd_result_unpacker. Inputs change and outputs are sampled on the
// falling clock edge; the DUT registers on the rising edge. A second instance with
// CARRY_EXT=0 shares the inputs to check the zero-extended format.

module tb_simd_result_unpacker;

    logic        clk;
    logic        reset;
    logic [1:0]  USE_SIMD;
    logic [31:0] S;
    logic [7:0]  flags;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,  in_ready_b;
    logic [32:0] out_data,  out_data_b;
    logic [2:0]  out_lane,  out_lane_b;
    logic        out_last,  out_last_b;
    logic        out_valid, out_valid_b;
    logic [15:0] beat_count, beat_count_b;

    int tests;
    int fails;

    simd_result_unpacker #(.CARRY_EXT(1)) dut (
        .clk(clk), .reset(reset), .USE_SIMD(USE_SIMD), .S(S),
        .result_SIMD_carry_out(flags), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .beat_count(beat_count)
    );

    simd_result_unpacker #(.CARRY_EXT(0)) dut_noext (
        .clk(clk), .reset(reset), .USE_SIMD(USE_SIMD), .S(S),
        .result_SIMD_carry_out(flags), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_lane(out_lane_b), .out_last(out_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .beat_count(beat_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present_word(input logic [1:0] mode, input logic [31:0] s,
                                input logic [7:0] f);
        @(negedge clk);
        USE_SIMD  = mode;
        S         = s;
        flags     = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        USE_SIMD = 2'b00; S = 32'd0; flags = 8'd0;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_data !== 33'd0 || out_lane !== 3'd0 ||
            out_last !== 1'b0 || beat_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: valid=%b data=%h lane=%0d last=%b beats=%0d, want all 0",
                     out_valid, out_data, out_lane, out_last, beat_count);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_4bit_lanes();
        logic [32:0] exp_d [8];
        exp_d = '{33'h11, 33'h2, 33'h3, 33'h4, 33'h5, 33'h6, 33'h7, 33'h18};
        present_word(2'b11, 32'h8765_4321, 8'b1000_0001);
        USE_SIMD = 2'b00; // mid-word mode change must not matter
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_lane !== 3'(k) || out_data !== exp_d[k] ||
                out_last !== (k == 7)) begin
                fails++;
                $display("FAIL lane4_beat%0d: valid=%b lane=%0d data=%h last=%b, want 1 %0d %h %b",
                         k, out_valid, out_lane, out_data, out_last, k, exp_d[k], (k == 7));
            end
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b0 || beat_count !== 16'd8) begin
            fails++;
            $display("FAIL lane4_done: valid=%b beats=%0d, want 0 8", out_valid, beat_count);
        end
    endtask

    task automatic test_16bit_lanes();
        present_word(2'b01, 32'hFFFF_0001, 8'b1000_1000);
        tests++;
        if (out_data !== 33'h1_0001 || out_data_b !== 33'h0_0001 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL lane16_beat0: data=%h noext=%h last=%b, want 10001 00001 0",
                     out_data, out_data_b, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_data !== 33'h1_FFFF || out_data_b !== 33'h0_FFFF || out_last !== 1'b1 ||
            out_lane !== 3'd1) begin
            fails++;
            $display("FAIL lane16_beat1: data=%h noext=%h last=%b lane=%0d, want 1ffff 0ffff 1 1",
                     out_data, out_data_b, out_last, out_lane);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || beat_count !== 16'd10) begin
            fails++;
            $display("FAIL lane16_done: valid=%b beats=%0d, want 0 10", out_valid, beat_count);
        end
    endtask

    task automatic test_32bit_lane();
        present_word(2'b00, 32'hDEAD_BEEF, 8'b1000_0000);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 33'h1_DEAD_BEEF || out_lane !== 3'd0 ||
            out_last !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL lane32: valid=%b data=%h lane=%0d last=%b in_ready=%b, want 1 1deadbeef 0 1 1",
                     out_valid, out_data, out_lane, out_last, in_ready);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || beat_count !== 16'd11) begin
            fails++;
            $display("FAIL lane32_done: valid=%b beats=%0d, want 0 11", out_valid, beat_count);
        end
    endtask

    task automatic test_backpressure();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        present_word(2'b10, 32'h4433_2211, 8'h00);
        tests++;
        if (out_data !== 33'h11) begin
            fails++;
            $display("FAIL bp_lane0: data=%h, want 11", out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 33'h22 || out_lane !== 3'd1 ||
                out_last !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%h lane=%0d last=%b in_ready=%b, want 1 22 1 0 0",
                         c, out_valid, out_data, out_lane, out_last, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_data !== 33'h33 || out_lane !== 3'd2) begin
            fails++;
            $display("FAIL bp_lane2: data=%h lane=%0d, want 33 2", out_data, out_lane);
        end
        @(negedge clk);
        tests++;
        if (out_data !== 33'h44 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL bp_lane3: data=%h last=%b, want 44 1", out_data, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || beat_count !== 16'd4) begin
            fails++;
            $display("FAIL bp_done: valid=%b beats=%0d, want 0 4", out_valid, beat_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_b [4];
        exp_b = '{33'hDD, 33'hCC, 33'hBB, 33'hAA};
        present_word(2'b01, 32'h1234_5678, 8'h00);
        tests++;
        if (out_data !== 33'h5678) begin
            fails++;
            $display("FAIL b2b_a0: data=%h, want 5678", out_data);
        end
        @(negedge clk);
        USE_SIMD = 2'b10; S = 32'hAABB_CCDD; flags = 8'h00; in_valid = 1'b1;
        #1;
        tests++;
        if (out_data !== 33'h1234 || out_last !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_a1: data=%h last=%b in_ready=%b, want 1234 1 1",
                     out_data, out_last, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_lane !== 3'(k) || out_data !== exp_b[k]) begin
                fails++;
                $display("FAIL b2b_b%0d: valid=%b lane=%0d data=%h, want 1 %0d %h",
                         k, out_valid, out_lane, out_data, k, exp_b[k]);
            end
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b0 || beat_count !== 16'd10) begin
            fails++;
            $display("FAIL b2b_done: valid=%b beats=%0d, want 0 10", out_valid, beat_count);
        end
    endtask

    task automatic test_reset_mid_word();
        int stray;
        present_word(2'b11, 32'h8765_4321, 8'h00);
        repeat (2) @(negedge clk);
        tests++;
        if (out_lane !== 3'd2 || out_data !== 33'h3) begin
            fails++;
            $display("FAIL rmid_lane2: lane=%0d data=%h, want 2 3", out_lane, out_data);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 33'd0 || out_lane !== 3'd0 ||
            out_last !== 1'b0 || beat_count !== 16'd0) begin
            fails++;
            $display("FAIL rmid_async: valid=%b data=%h lane=%0d last=%b beats=%0d, want all 0",
                     out_valid, out_data, out_lane, out_last, beat_count);
        end
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0 || beat_count !== 16'd0) begin
            fails++;
            $display("FAIL rmid_after: stray_beats=%0d beats=%0d, want 0 0", stray, beat_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_4bit_lanes();
        test_16bit_lanes();
        test_32bit_lane();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
